// File: rtl/trace_pkg.sv
// Shared types and helpers for the trace packer: beat classification,
// popcount, pointer-width derivation and circular lane addressing.
package trace_pkg;

  localparam int MAX_NCH = 8;

  typedef enum logic [1:0] {
    BEAT_NONE  = 2'd0,
    BEAT_FULL  = 2'd1,
    BEAT_FLUSH = 2'd2
  } beat_kind_e;

  function automatic logic [3:0] popcount(input logic [MAX_NCH-1:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < MAX_NCH; i++) begin
      s = s + {3'd0, v[i]};
    end
    return s;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lane_addr(input int rd, input int k, input int depth);
    return (rd + k) % depth;
  endfunction

endpackage

// File: rtl/trace_packer_if.sv
// Output beat stream of the trace packer (valid/ready with per-lane keep).
interface trace_packer_if #(
  parameter int W     = 64,
  parameter int LANES = 2
);
  logic [LANES*W-1:0] out_data;
  logic [LANES-1:0]   out_keep;
  logic               out_valid;
  logic               out_ready;

  modport master (output out_data, output out_keep, output out_valid, input out_ready);
  modport slave  (input out_data, input out_keep, input out_valid, output out_ready);
endinterface

// File: rtl/trace_compactor.sv
// Packs the enabled channel words into the low slots in ascending channel
// order using a running prefix count of the enables.
module trace_compactor
  import trace_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 64,
  parameter int NW  = 3
) (
  input  logic [NCH*W-1:0] trace_data,
  input  logic [NCH-1:0]   trace_en,
  output logic [NCH*W-1:0] packed_data,
  output logic [NW-1:0]    n
);

  logic [NW-1:0] slot;

  // prefix-sum placement of enabled words
  always_comb begin
    packed_data = '0;
    slot        = '0;
    for (int c = 0; c < NCH; c++) begin
      if (trace_en[c]) begin
        packed_data[slot*W +: W] = trace_data[c*W +: W];
        slot                     = slot + NW'(1);
      end else begin
        slot = slot;
      end
    end
  end

  assign n = NW'(popcount(MAX_NCH'(trace_en)));

endmodule

// File: rtl/trace_packer.sv
// Compacts per-cycle trace records into a circular word buffer and emits
// them as LANES-word beats, with flush, all-or-nothing admission and drop stats.
module trace_packer
  import trace_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int W         = 64,
  parameter int LANES     = 2,
  parameter int DEPTH     = 16,
  parameter int DROP_MODE = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk_clk,
  input  logic             reset,
  input  logic [NCH*W-1:0] trace_data,
  input  logic [NCH-1:0]   trace_en,
  input  logic             flush,
  output logic             full,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow,
  trace_packer_if.master   out
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(NCH + 1);

  if (DROP_MODE != 0 && DROP_MODE != 1) begin : g_bad_mode
    $error("trace_packer: DROP_MODE must be 0 or 1");
  end

  logic [W-1:0]       mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count, count_after, space, pop_n, count_next;
  logic               flush_pend;
  logic [NCH*W-1:0]   packed_data;
  logic [NW-1:0]      n, written;
  logic               accept, drop, fire;
  beat_kind_e         kind;
  logic [LANES*W-1:0] lane_data;
  logic [LANES-1:0]   lane_keep, keep_out;

  trace_compactor #(.NCH(NCH), .W(W), .NW(NW)) u_compactor (
    .trace_data  (trace_data),
    .trace_en    (trace_en),
    .packed_data (packed_data),
    .n           (n)
  );

  // classify the beat currently presented
  always_comb begin
    if (count >= CW'(LANES)) begin
      kind = BEAT_FULL;
    end else if (flush_pend && count != '0) begin
      kind = BEAT_FLUSH;
    end else begin
      kind = BEAT_NONE;
    end
  end

  // lanes beyond the residual drive zero with keep low
  always_comb begin
    lane_data = '0;
    lane_keep = '0;
    for (int k = 0; k < LANES; k++) begin
      if (CW'(k) < count) begin
        lane_data[k*W +: W] = mem[PW'(lane_addr(int'(rd_ptr), k, DEPTH))];
        lane_keep[k]        = 1'b1;
      end else begin
        lane_data[k*W +: W] = '0;
        lane_keep[k]        = 1'b0;
      end
    end
  end

  always_comb begin
    case (kind)
      BEAT_FULL:  keep_out = '1;
      BEAT_FLUSH: keep_out = lane_keep;
      default:    keep_out = '0;
    endcase
  end

  assign out.out_valid = (kind != BEAT_NONE);
  assign out.out_data  = lane_data;
  assign out.out_keep  = keep_out;
  assign fire          = out.out_valid & out.out_ready;

  // admission sees the space freed by a same-cycle pop
  always_comb begin
    if (fire) begin
      pop_n = (kind == BEAT_FULL) ? CW'(LANES) : count;
    end else begin
      pop_n = '0;
    end
    count_after = count - pop_n;
    space       = CW'(DEPTH) - count_after;
    accept      = (CW'(n) <= space);
    written     = accept ? n : '0;
    drop        = (n != '0) && !accept;
    count_next  = count_after + CW'(written);
  end

  // buffer storage carries no reset
  always_ff @(posedge clk_clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (accept && (NW'(i) < n)) begin
        mem[wr_ptr + PW'(i)] <= packed_data[i*W +: W];
      end
    end
  end

  // pointers, occupancy, flush and drop state
  always_ff @(posedge clk_clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      flush_pend <= 1'b0;
      full       <= 1'b0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(written);
      rd_ptr     <= rd_ptr + PW'(pop_n);
      count      <= count_next;
      flush_pend <= (flush_pend | flush) & (count_next != '0);
      full       <= (CW'(DEPTH) - count_next) < CW'(NCH);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_trace_packer.sv
// Self-checking bench for trace_packer: directed scenarios plus random traffic
// compared against a queue-based model of the packing rules.
module tb_trace_packer;
  localparam int NCH   = 4;
  localparam int W     = 64;
  localparam int LANES = 2;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic             clk_clk;
  logic             reset;
  logic [NCH*W-1:0] trace_data;
  logic [NCH-1:0]   trace_en;
  logic             flush;
  logic             full;
  logic [CNT_W-1:0] drop_count;
  logic             overflow;

  trace_packer_if #(.W(W), .LANES(LANES)) bus ();

  trace_packer #(.NCH(NCH), .W(W), .LANES(LANES), .DEPTH(DEPTH), .DROP_MODE(1), .CNT_W(CNT_W)) dut (
    .clk_clk    (clk_clk),
    .reset      (reset),
    .trace_data (trace_data),
    .trace_en   (trace_en),
    .flush      (flush),
    .full       (full),
    .drop_count (drop_count),
    .overflow   (overflow),
    .out        (bus)
  );

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  int               checks   = 0;
  int               failures = 0;
  logic [W-1:0]     q[$];
  bit               pend;
  logic [CNT_W-1:0] exp_dc;
  bit               exp_ov;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH*W-1:0] mk(input logic [W-1:0] w0, input logic [W-1:0] w1,
                                           input logic [W-1:0] w2, input logic [W-1:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [W-1:0] rnd_word();
    return {$urandom(), $urandom()};
  endfunction

  // One clock cycle: check presented outputs against the model, then advance both.
  task automatic step(input logic [NCH-1:0] en, input logic [NCH*W-1:0] d,
                      input logic fl, input logic rdy);
    int                 sz;
    int                 n;
    bit                 ev;
    logic [LANES*W-1:0] ed;
    logic [LANES-1:0]   ek;
    trace_en      = en;
    trace_data    = d;
    flush         = fl;
    bus.out_ready = rdy;
    sz = q.size();
    ev = (sz >= LANES) || (pend && sz > 0);
    ed = '0;
    ek = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < sz) begin
        ed[k*W +: W] = q[k];
        ek[k]        = 1'b1;
      end
    end
    #1;
    chk("valid", bus.out_valid, ev);
    if (ev) chk("data", bus.out_data, ed);
    if (ev && rdy) chk("keep", bus.out_keep, ek);
    chk("full", full, (DEPTH - sz) < NCH);
    chk("drop_count", drop_count, exp_dc);
    chk("overflow", overflow, exp_ov);
    if (ev && rdy) begin
      for (int k = 0; k < LANES && q.size() > 0; k++) void'(q.pop_front());
    end
    n = 0;
    for (int c = 0; c < NCH; c++) if (en[c]) n++;
    if (n > 0) begin
      if (n <= DEPTH - q.size()) begin
        for (int c = 0; c < NCH; c++) if (en[c]) q.push_back(d[c*W +: W]);
      end else begin
        exp_ov = 1'b1;
        if (exp_dc != '1) exp_dc = exp_dc + 1'b1;
      end
    end
    pend = (pend || fl) && (q.size() != 0);
    @(posedge clk_clk);
    @(negedge clk_clk);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    trace_en      = '0;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_keep", bus.out_keep, 2'b00);
    chk("rst_full", full, 1'b0);
    chk("rst_drop", drop_count, 16'h0000);
    chk("rst_ovf", overflow, 1'b0);
    q.delete();
    pend   = 1'b0;
    exp_dc = '0;
    exp_ov = 1'b0;
    @(negedge clk_clk);
    reset = 1'b0;
  endtask

  logic [W-1:0]     w0, w1;
  logic [NCH*W-1:0] d;

  initial begin
    reset = 1'b0; trace_en = '0; trace_data = '0; flush = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk_clk);
    do_reset();

    // single record, immediate beat
    step(4'b1010, mk(64'h0, 64'hA1, 64'h0, 64'hA3), 1'b0, 1'b1);
    chk("t1_data", bus.out_data, {64'hA3, 64'hA1});
    step(4'b0000, '0, 1'b0, 1'b1);
    chk("t1_empty", bus.out_valid, 1'b0);

    // fill to capacity, then drop a record
    do_reset();
    w0 = rnd_word(); w1 = rnd_word();
    step(4'b1111, mk(w0, w1, rnd_word(), rnd_word()), 1'b0, 1'b0);
    step(4'b1111, mk(rnd_word(), rnd_word(), rnd_word(), rnd_word()), 1'b0, 1'b0);
    step(4'b1111, mk(rnd_word(), rnd_word(), rnd_word(), rnd_word()), 1'b0, 1'b0);
    chk("t2_full_at12", full, 1'b0);
    step(4'b1111, mk(rnd_word(), rnd_word(), rnd_word(), rnd_word()), 1'b0, 1'b0);
    chk("t2_full_at16", full, 1'b1);
    step(4'b0001, mk(64'hDEAD, 64'h0, 64'h0, 64'h0), 1'b0, 1'b0);
    chk("t2_drop", drop_count, 16'h0001);
    chk("t2_ovf", overflow, 1'b1);
    chk("t2_head", bus.out_data, {w1, w0});

    // partial flush
    do_reset();
    step(4'b0111, mk(64'd1, 64'd2, 64'd3, 64'h0), 1'b0, 1'b1);
    chk("t3_beat0", bus.out_data, {64'd2, 64'd1});
    step(4'b0000, '0, 1'b1, 1'b1);
    chk("t3_beat1", bus.out_data, {64'd0, 64'd3});
    chk("t3_keep1", bus.out_keep, 2'b01);
    step(4'b0000, '0, 1'b0, 1'b1);
    chk("t3_idle", bus.out_valid, 1'b0);
    step(4'b0001, mk(64'd9, 64'h0, 64'h0, 64'h0), 1'b0, 1'b1);
    chk("t3_pend_clear", bus.out_valid, 1'b0);
    step(4'b0000, '0, 1'b1, 1'b1);

    // write and pop together at count 15, wrapping the write pointer
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b1111, mk(rnd_word(), rnd_word(), rnd_word(), rnd_word()), 1'b0, 1'b0);
    step(4'b0111, mk(rnd_word(), rnd_word(), rnd_word(), 64'h0), 1'b0, 1'b0);
    step(4'b0011, mk(64'hC0, 64'hC1, 64'h0, 64'h0), 1'b0, 1'b1);
    chk("t4_no_drop", drop_count, 16'h0000);
    chk("t4_full15", full, 1'b1);
    for (int i = 0; i < 8; i++) step(4'b0000, '0, 1'b0, 1'b1);
    chk("t4_tail", bus.out_data[W-1:0], 64'hC1);
    step(4'b0000, '0, 1'b1, 1'b1);
    step(4'b0000, '0, 1'b0, 1'b1);

    // reset in the middle of a stream
    step(4'b1111, mk(rnd_word(), rnd_word(), rnd_word(), rnd_word()), 1'b0, 1'b0);
    step(4'b1111, mk(rnd_word(), rnd_word(), rnd_word(), rnd_word()), 1'b0, 1'b0);
    step(4'b0011, mk(rnd_word(), rnd_word(), 64'h0, 64'h0), 1'b0, 1'b0);
    do_reset();
    step(4'b0011, mk(64'h51, 64'h52, 64'h0, 64'h0), 1'b0, 1'b0);
    chk("t5_first", bus.out_data, {64'h52, 64'h51});

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      d = mk(rnd_word(), rnd_word(), rnd_word(), rnd_word());
      step(4'($urandom_range(0, 15)), d, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end

    // drop counter saturation
    do_reset();
    for (int i = 0; i < 4; i++) step(4'b1111, mk(rnd_word(), rnd_word(), rnd_word(), rnd_word()), 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) step(4'b0001, mk(rnd_word(), 64'h0, 64'h0, 64'h0), 1'b0, 1'b0);
    chk("sat_drop", drop_count, 16'hFFFF);
    chk("sat_ovf", overflow, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
